// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and counter sizing for the bit-serial adder
package serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   // Wide enough to hold WIDTH itself, so WIDTH=1 still gets a 1-bit counter.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - 1-bit full-adder cell
module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign sum  = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock through a single full-adder cell
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q,  a_sr_d;
   logic [WIDTH-1:0] b_sr_q,  b_sr_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q,  cout_d;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] acc_shift;

   serial_adder_fa u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // New sum bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts.
   if (WIDTH == 1) begin : g_acc_one
      assign acc_shift = fa_sum;
   end else begin : g_acc_wide
      assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT;
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         S_SHIFT: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            acc_d   = acc_shift;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               sum_d   = acc_shift;
               cout_d  = fa_cout;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
